rs_dispatch_alloc: RTL and testbench

- Parametrised dispatch/allocation stage between rename and the reservation stations (RS).
- Latches a DISP_W-wide instruction group and checks that every RS class has room for it.
- Allocates the lowest free entries and issues registered write strobes and addresses.
- Owns the per-RS busy vectors and per-entry speculation tags; frees entries on issue release and on branch kill.

---
 rtl/rs_pkg.sv | 34 +++
 rtl/rs_free_pick.sv | 36 +++
 rtl/rs_dispatch_alloc.sv | 217 +++++++++++++++++++++
 tb/tb_rs_dispatch_alloc.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared types and defaults for the RS dispatch/allocation slice.
// Holds RS class ids, default sizes, the per-slot bundle and a popcount helper.
package rs_pkg;

    localparam int DISP_W_DEF   = 2;
    localparam int NUM_RS_DEF   = 4;
    localparam int RS_DEPTH_DEF = 8;
    localparam int SPEC_W_DEF   = 4;
    localparam int RSID_W_DEF   = $clog2(NUM_RS_DEF);

    typedef enum logic [RSID_W_DEF-1:0] {
        RS_ALU,
        RS_BRA,
        RS_LDST,
        RS_MUL
    } rs_class_e;

    // One dispatch slot as seen by the holding register
    typedef struct packed {
        logic                  valid;
        logic [RSID_W_DEF-1:0] rs_id;
        logic [SPEC_W_DEF-1:0] spec_tag;
    } slot_t;

    function automatic int count_ones(input logic [63:0] v);
        int n;
        n = 0;
        for (int k = 0; k < 64; k++) begin
            n += int'(v[k]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rs_free_pick.sv
// Finds the first DISP_W free entries of one RS busy vector, lowest index first.
// Ports: busy_i busy vector in; idx_o packed entry indices out; vld_o per-pick valid.
module rs_free_pick #(
    parameter int RS_DEPTH = 8,
    parameter int DISP_W   = 2,
    parameter int IDX_W    = $clog2(RS_DEPTH)
) (
    input  logic [RS_DEPTH-1:0]     busy_i,
    output logic [DISP_W*IDX_W-1:0] idx_o,
    output logic [DISP_W-1:0]       vld_o
);

    logic [DISP_W-1:0][IDX_W-1:0] idx;
    logic [RS_DEPTH-1:0]          avail;

    always_comb begin
        idx   = '0;
        vld_o = '0;
        avail = ~busy_i;
        for (int k = 0; k < DISP_W; k++) begin
            // Descending scan: the last hit is the lowest free index
            for (int e = RS_DEPTH - 1; e >= 0; e--) begin
                if (avail[e]) begin
                    idx[k]   = IDX_W'(e);
                    vld_o[k] = 1'b1;
                end
            end
            if (vld_o[k]) begin
                avail[idx[k]] = 1'b0;
            end
        end
    end

    assign idx_o = idx;

endmodule

// File: rtl/rs_dispatch_alloc.sv
// Dispatch stage: holds one rename group, allocates RS entries all-or-nothing.
// Ports: in_* group + in_ready; stall; br_* resolve; rel_* frees; dp_* writes; busy/free_cnt.
module rs_dispatch_alloc
    import rs_pkg::*;
#(
    parameter int DISP_W   = DISP_W_DEF,
    parameter int NUM_RS   = NUM_RS_DEF,
    parameter int RS_DEPTH = RS_DEPTH_DEF,
    parameter int SPEC_W   = SPEC_W_DEF,
    parameter int RSID_W   = $clog2(NUM_RS),
    parameter int IDX_W    = $clog2(RS_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DISP_W-1:0]            in_valid,
    input  logic [DISP_W*RSID_W-1:0]     in_rs_id,
    input  logic [DISP_W*SPEC_W-1:0]     in_spec_tag,
    output logic                         in_ready,
    input  logic                         stall,
    input  logic                         br_kill,
    input  logic                         br_clear,
    input  logic [SPEC_W-1:0]            br_mask,
    input  logic [NUM_RS-1:0]            rel_valid,
    input  logic [NUM_RS*IDX_W-1:0]      rel_idx,
    output logic [DISP_W-1:0]            dp_we,
    output logic [DISP_W*RSID_W-1:0]     dp_rs_id,
    output logic [DISP_W*IDX_W-1:0]      dp_waddr,
    output logic [NUM_RS*RS_DEPTH-1:0]   busy,
    output logic [NUM_RS*(IDX_W+1)-1:0]  free_cnt
);

    localparam int RK_W = (DISP_W > 1) ? $clog2(DISP_W) : 1;

    // Unflattened views of the packed ports
    logic [DISP_W-1:0][RSID_W-1:0] in_id_w;
    logic [DISP_W-1:0][SPEC_W-1:0] in_tag_w;
    logic [NUM_RS-1:0][IDX_W-1:0]  rel_id_w;

    assign in_id_w  = in_rs_id;
    assign in_tag_w = in_spec_tag;
    assign rel_id_w = rel_idx;

    // Holding register; the group is valid when any slot is valid
    logic [DISP_W-1:0]             hval_q, hval_d;
    logic [DISP_W-1:0][RSID_W-1:0] hid_q, hid_d;
    logic [DISP_W-1:0][SPEC_W-1:0] htag_q, htag_d;

    logic [NUM_RS-1:0][RS_DEPTH-1:0]             busy_q, busy_d;
    logic [NUM_RS-1:0][RS_DEPTH-1:0][SPEC_W-1:0] tag_q, tag_d;
    logic [NUM_RS-1:0][IDX_W:0]                  fcnt_q, fcnt_d;

    logic [DISP_W-1:0]             we_q, we_d;
    logic [DISP_W-1:0][RSID_W-1:0] rid_q, rid_d;
    logic [DISP_W-1:0][IDX_W-1:0]  wa_q, wa_d;

    logic [NUM_RS-1:0][DISP_W-1:0][IDX_W-1:0] pick_idx;
    logic [NUM_RS-1:0][DISP_W-1:0]            pick_vld;

    logic [DISP_W-1:0][RK_W-1:0]  rank;
    logic [DISP_W-1:0][IDX_W-1:0] slot_wa;
    logic                         fits;
    logic                         h_any;
    logic                         fire;
    logic                         accept;

    for (genvar r = 0; r < NUM_RS; r++) begin : g_pick
        rs_free_pick #(
            .RS_DEPTH (RS_DEPTH),
            .DISP_W   (DISP_W),
            .IDX_W    (IDX_W)
        ) u_pick (
            .busy_i (busy_q[r]),
            .idx_o  (pick_idx[r]),
            .vld_o  (pick_vld[r])
        );
    end

    // rank = position of a slot among valid slots aiming at the same RS.
    // A slot with rank k needs at least k+1 free entries, so checking
    // pick_vld at that rank is the same as count <= free_cnt per RS.
    always_comb begin
        rank    = '0;
        slot_wa = '0;
        fits    = 1'b1;
        for (int i = 0; i < DISP_W; i++) begin
            for (int j = 0; j < i; j++) begin
                if (hval_q[j] && (hid_q[j] == hid_q[i])) begin
                    rank[i] = rank[i] + 1'b1;
                end
            end
            slot_wa[i] = pick_idx[hid_q[i]][rank[i]];
            if (hval_q[i] && !pick_vld[hid_q[i]][rank[i]]) begin
                fits = 1'b0;
            end
        end
    end

    assign h_any    = |hval_q;
    assign fire     = h_any && fits && !stall && !br_kill;
    assign in_ready = !br_kill && (!h_any || fire);
    assign accept   = (|in_valid) && in_ready;

    // Holding register next state
    always_comb begin
        hval_d = hval_q;
        hid_d  = hid_q;
        htag_d = htag_q;
        if (accept) begin
            hval_d = in_valid;
            hid_d  = in_id_w;
            htag_d = in_tag_w;
        end else if (br_kill || fire) begin
            hval_d = '0;
        end else if (br_clear) begin
            for (int i = 0; i < DISP_W; i++) begin
                htag_d[i] = htag_q[i] & ~br_mask;
            end
        end
    end

    // Busy and tag next state: release, kill/clear, then allocation.
    // Allocation only targets non-busy entries, so it never collides
    // with a legal release or kill of the same entry.
    always_comb begin
        busy_d = busy_q;
        tag_d  = tag_q;
        for (int r = 0; r < NUM_RS; r++) begin
            if (rel_valid[r]) begin
                busy_d[r][rel_id_w[r]] = 1'b0;
            end
        end
        for (int r = 0; r < NUM_RS; r++) begin
            for (int e = 0; e < RS_DEPTH; e++) begin
                if (br_kill) begin
                    if ((tag_q[r][e] & br_mask) != '0) begin
                        busy_d[r][e] = 1'b0;
                    end
                end else if (br_clear) begin
                    tag_d[r][e] = tag_q[r][e] & ~br_mask;
                end
            end
        end
        if (fire) begin
            for (int i = 0; i < DISP_W; i++) begin
                if (hval_q[i]) begin
                    busy_d[hid_q[i]][slot_wa[i]] = 1'b1;
                    tag_d[hid_q[i]][slot_wa[i]] =
                        br_clear ? (htag_q[i] & ~br_mask) : htag_q[i];
                end
            end
        end
    end

    always_comb begin
        fcnt_d = '0;
        for (int r = 0; r < NUM_RS; r++) begin
            fcnt_d[r] = (IDX_W+1)'(RS_DEPTH
                      - count_ones(64'(busy_d[r])));
        end
    end

    // Write port outputs; addresses hold when nothing fires
    always_comb begin
        we_d  = fire ? hval_q : '0;
        rid_d = rid_q;
        wa_d  = wa_q;
        if (fire) begin
            for (int i = 0; i < DISP_W; i++) begin
                if (hval_q[i]) begin
                    rid_d[i] = hid_q[i];
                    wa_d[i]  = slot_wa[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hval_q <= '0;
            hid_q  <= '0;
            htag_q <= '0;
            busy_q <= '0;
            tag_q  <= '0;
            we_q   <= '0;
            rid_q  <= '0;
            wa_q   <= '0;
            for (int r = 0; r < NUM_RS; r++) begin
                fcnt_q[r] <= (IDX_W+1)'(RS_DEPTH);
            end
        end else begin
            hval_q <= hval_d;
            hid_q  <= hid_d;
            htag_q <= htag_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
            fcnt_q <= fcnt_d;
            we_q   <= we_d;
            rid_q  <= rid_d;
            wa_q   <= wa_d;
        end
    end

    assign dp_we    = we_q;
    assign dp_rs_id = rid_q;
    assign dp_waddr = wa_q;
    assign busy     = busy_q;
    assign free_cnt = fcnt_q;

    // Releasing an entry that is not busy points at an issue-side bug
    for (genvar r = 0; r < NUM_RS; r++) begin : g_rel_chk
        a_rel_busy: assert property (
            @(posedge clk) disable iff (rst)
            rel_valid[r] |-> busy_q[r][rel_id_w[r]]
        );
    end

endmodule

// File: tb/tb_rs_dispatch_alloc.sv
// Self-checking bench for rs_dispatch_alloc: directed table, hand sequences,
// then random traffic compared against a queue/array reference model.
module tb_rs_dispatch_alloc;
    import rs_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  in_valid;
    logic [3:0]  in_rs_id;
    logic [7:0]  in_spec_tag;
    logic        in_ready;
    logic        stall;
    logic        br_kill;
    logic        br_clear;
    logic [3:0]  br_mask;
    logic [3:0]  rel_valid;
    logic [11:0] rel_idx;
    logic [1:0]  dp_we;
    logic [3:0]  dp_rs_id;
    logic [5:0]  dp_waddr;
    logic [31:0] busy;
    logic [15:0] free_cnt;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rs_dispatch_alloc dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_rs_id    (in_rs_id),
        .in_spec_tag (in_spec_tag),
        .in_ready    (in_ready),
        .stall       (stall),
        .br_kill     (br_kill),
        .br_clear    (br_clear),
        .br_mask     (br_mask),
        .rel_valid   (rel_valid),
        .rel_idx     (rel_idx),
        .dp_we       (dp_we),
        .dp_rs_id    (dp_rs_id),
        .dp_waddr    (dp_waddr),
        .busy        (busy),
        .free_cnt    (free_cnt)
    );

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit         model_ok = 1'b0;
    bit         mb[4][8];
    logic [3:0] mt[4][8];
    bit         mhv[2];
    int         mhid[2];
    logic [3:0] mhtag[2];
    bit   [1:0] mwe;
    int         mdid[2];
    int         mdwa[2];

    function automatic bit m_fire();
        int need[4];
        int freec;
        if (!(mhv[0] || mhv[1]) || stall || br_kill) return 1'b0;
        need = '{default: 0};
        for (int i = 0; i < 2; i++) if (mhv[i]) need[mhid[i]]++;
        for (int r = 0; r < 4; r++) begin
            freec = 0;
            for (int e = 0; e < 8; e++) if (!mb[r][e]) freec++;
            if (need[r] > freec) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit m_ready();
        return !br_kill && (!(mhv[0] || mhv[1]) || m_fire());
    endfunction

    task automatic model_step();
        bit         f;
        bit         acc;
        bit         nb[4][8];
        logic [3:0] nt[4][8];
        bit         taken[4][8];
        int         r;
        if (rst) begin
            mb = '{default: '0};
            mt = '{default: '0};
            mhv = '{default: 0};
            mwe = '0;
            mdid = '{default: 0};
            mdwa = '{default: 0};
            model_ok = 1'b1;
            return;
        end
        f = m_fire();
        acc = (in_valid != 0) && m_ready();
        nb = mb;
        nt = mt;
        taken = '{default: '0};
        mwe = '0;
        if (f) begin
            for (int i = 0; i < 2; i++) begin
                if (mhv[i]) begin
                    r = mhid[i];
                    for (int e = 0; e < 8; e++) begin
                        if (!mb[r][e] && !taken[r][e]) begin
                            taken[r][e] = 1'b1;
                            nb[r][e] = 1'b1;
                            nt[r][e] = br_clear ? (mhtag[i] & ~br_mask)
                                                : mhtag[i];
                            mdid[i] = r;
                            mdwa[i] = e;
                            mwe[i] = 1'b1;
                            break;
                        end
                    end
                end
            end
        end
        for (int q = 0; q < 4; q++)
            if (rel_valid[q]) nb[q][rel_idx[q*3 +: 3]] = 1'b0;
        for (int q = 0; q < 4; q++) begin
            for (int e = 0; e < 8; e++) begin
                if (br_kill) begin
                    if (mb[q][e] && ((mt[q][e] & br_mask) != 0))
                        nb[q][e] = 1'b0;
                end else if (br_clear && !taken[q][e]) begin
                    nt[q][e] = mt[q][e] & ~br_mask;
                end
            end
        end
        if (acc) begin
            for (int i = 0; i < 2; i++) begin
                mhv[i] = in_valid[i];
                mhid[i] = int'(in_rs_id[i*2 +: 2]);
                mhtag[i] = in_spec_tag[i*4 +: 4];
            end
        end else if (br_kill || f) begin
            mhv = '{default: 0};
        end else if (br_clear) begin
            for (int i = 0; i < 2; i++) mhtag[i] = mhtag[i] & ~br_mask;
        end
        mb = nb;
        mt = nt;
    endtask

    task automatic compare_all();
        logic [31:0] eb;
        logic [15:0] ef;
        int c;
        if (!model_ok) return;
        check("m_rdy", 64'(in_ready), 64'(m_ready()));
        check("m_we", 64'(dp_we), 64'(mwe));
        for (int i = 0; i < 2; i++) begin
            if (mwe[i]) begin
                check("m_rsid", 64'(dp_rs_id[i*2 +: 2]), 64'(mdid[i]));
                check("m_waddr", 64'(dp_waddr[i*3 +: 3]), 64'(mdwa[i]));
            end
        end
        for (int r = 0; r < 4; r++) begin
            c = 0;
            for (int e = 0; e < 8; e++) begin
                eb[r*8 + e] = mb[r][e];
                if (!mb[r][e]) c++;
            end
            ef[r*4 +: 4] = 4'(c);
        end
        check("m_busy", 64'(busy), 64'(eb));
        check("m_free", 64'(free_cnt), 64'(ef));
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        rst = 1'b0;
        in_valid = '0;
        in_rs_id = '0;
        in_spec_tag = '0;
        stall = 1'b0;
        br_kill = 1'b0;
        br_clear = 1'b0;
        br_mask = '0;
        rel_valid = '0;
        rel_idx = '0;
    endtask

    task automatic send(input logic [1:0] v, input logic [3:0] id,
                        input logic [7:0] tg);
        idle();
        in_valid = v;
        in_rs_id = id;
        in_spec_tag = tg;
    endtask

    task automatic push(input logic [1:0] v, input logic [3:0] id,
                        input logic [7:0] tg);
        send(v, id, tg);
        tick();
        idle();
        tick();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          rst;
        slot_t [1:0] s;
        bit          stall;
        bit          chk_rdy;
        bit          rdy;
        logic [1:0]  we;
        logic [3:0]  did;
        logic [5:0]  wa;
        logic [31:0] bsy;
        logic [15:0] fc;
    } vec_t;

    function automatic vec_t mk(bit r, slot_t s0, slot_t s1, bit st,
                                bit cr, bit rd, logic [1:0] we,
                                logic [3:0] did, logic [5:0] wa,
                                logic [31:0] b, logic [15:0] fc);
        vec_t v;
        v.rst = r;
        v.s[0] = s0;
        v.s[1] = s1;
        v.stall = st;
        v.chk_rdy = cr;
        v.rdy = rd;
        v.we = we;
        v.did = did;
        v.wa = wa;
        v.bsy = b;
        v.fc = fc;
        return v;
    endfunction

    vec_t tbl[10];

    initial begin
        slot_t sz;
        slot_t sa;
        slot_t sl;
        logic [5:0] wm;
        logic [3:0] im;
        int e;
        int k;

        idle();
        rst = 1'b1;

        sz = '0;
        sa = '{valid: 1'b1, rs_id: RS_ALU, spec_tag: 4'h0};
        sl = '{valid: 1'b1, rs_id: RS_LDST, spec_tag: 4'h0};

        tbl[0] = mk(1, sz, sz, 0, 0, 0, 2'b00, 4'h0, 6'o00,
                    32'h0000_0000, 16'h8888);
        tbl[1] = mk(0, sa, sa, 0, 1, 1, 2'b00, 4'h0, 6'o00,
                    32'h0000_0000, 16'h8888);
        tbl[2] = mk(0, sz, sz, 0, 1, 1, 2'b11, 4'h0, 6'o10,
                    32'h0000_0003, 16'h8886);
        tbl[3] = mk(0, sz, sz, 0, 1, 1, 2'b00, 4'h0, 6'o00,
                    32'h0000_0003, 16'h8886);
        tbl[4] = mk(0, sz, sl, 0, 1, 1, 2'b00, 4'h0, 6'o00,
                    32'h0000_0003, 16'h8886);
        tbl[5] = mk(0, sz, sz, 1, 1, 0, 2'b00, 4'h0, 6'o00,
                    32'h0000_0003, 16'h8886);
        tbl[6] = mk(0, sz, sz, 1, 1, 0, 2'b00, 4'h0, 6'o00,
                    32'h0000_0003, 16'h8886);
        tbl[7] = mk(0, sz, sz, 1, 1, 0, 2'b00, 4'h0, 6'o00,
                    32'h0000_0003, 16'h8886);
        tbl[8] = mk(0, sz, sz, 0, 1, 1, 2'b10, 4'b1000, 6'o00,
                    32'h0001_0003, 16'h8786);
        tbl[9] = mk(0, sz, sz, 0, 1, 1, 2'b00, 4'h0, 6'o00,
                    32'h0001_0003, 16'h8786);

        for (int n = 0; n < 10; n++) begin
            idle();
            rst = tbl[n].rst;
            in_valid = {tbl[n].s[1].valid, tbl[n].s[0].valid};
            in_rs_id = {tbl[n].s[1].rs_id, tbl[n].s[0].rs_id};
            in_spec_tag = {tbl[n].s[1].spec_tag, tbl[n].s[0].spec_tag};
            stall = tbl[n].stall;
            #1;
            if (tbl[n].chk_rdy)
                check("tbl_rdy", 64'(in_ready), 64'(tbl[n].rdy));
            tick();
            check("tbl_we", 64'(dp_we), 64'(tbl[n].we));
            check("tbl_busy", 64'(busy), 64'(tbl[n].bsy));
            check("tbl_free", 64'(free_cnt), 64'(tbl[n].fc));
            wm = {{3{tbl[n].we[1]}}, {3{tbl[n].we[0]}}};
            im = {{2{tbl[n].we[1]}}, {2{tbl[n].we[0]}}};
            if (tbl[n].we != 0) begin
                check("tbl_waddr", 64'(dp_waddr & wm), 64'(tbl[n].wa & wm));
                check("tbl_rsid", 64'(dp_rs_id & im), 64'(tbl[n].did & im));
            end
        end

        // MUL fills to 7, a pair waits, a release lets it fire
        push(2'b11, 4'hF, 8'h00);
        push(2'b11, 4'hF, 8'h00);
        push(2'b11, 4'hF, 8'h00);
        push(2'b01, 4'h3, 8'h00);
        check("mul7_busy", 64'(busy[31:24]), 64'h7F);
        check("mul7_free", 64'(free_cnt[15:12]), 64'd1);
        send(2'b11, 4'hF, 8'h00);
        #1;
        check("mul_acc_rdy", 64'(in_ready), 64'd1);
        tick();
        idle();
        #1;
        check("mul_full_rdy", 64'(in_ready), 64'd0);
        tick();
        check("mul_full_we", 64'(dp_we), 64'd0);
        rel_valid = 4'b1000;
        rel_idx = 12'(3 << 9);
        tick();
        check("mul_rel_we", 64'(dp_we), 64'd0);
        check("mul_rel_busy", 64'(busy[31:24]), 64'h77);
        idle();
        #1;
        check("mul_go_rdy", 64'(in_ready), 64'd1);
        tick();
        check("mul_go_we", 64'(dp_we), 64'b11);
        check("mul_go_waddr", 64'(dp_waddr), 64'o73);
        check("mul_go_busy", 64'(busy[31:24]), 64'hFF);
        check("mul_go_free", 64'(free_cnt[15:12]), 64'd0);

        // Kill of branch 0 frees BRA 0,1, keeps ALU 2, drops H
        push(2'b11, 4'b0101, 8'h11);
        push(2'b01, 4'h0, 8'h02);
        check("kill_pre_alu", 64'(busy[7:0]), 64'h07);
        check("kill_pre_bra", 64'(busy[15:8]), 64'h03);
        send(2'b11, 4'b1010, 8'h00);
        tick();
        idle();
        stall = 1'b1;
        br_kill = 1'b1;
        br_mask = 4'b0001;
        #1;
        check("kill_rdy", 64'(in_ready), 64'd0);
        tick();
        check("kill_bra", 64'(busy[15:8]), 64'h00);
        check("kill_alu", 64'(busy[7:0]), 64'h07);
        check("kill_we", 64'(dp_we), 64'd0);
        idle();
        #1;
        check("kill_h_rdy", 64'(in_ready), 64'd1);
        tick();
        check("kill_h_we", 64'(dp_we), 64'd0);
        check("kill_ldst", 64'(busy[23:16]), 64'h01);

        // Clear of branch 1 protects ALU 2 from a later kill
        idle();
        br_clear = 1'b1;
        br_mask = 4'b0010;
        tick();
        idle();
        br_kill = 1'b1;
        br_mask = 4'b0010;
        tick();
        idle();
        check("clr_alu", 64'(busy[7:0]), 64'h07);
        check("clr_free", 64'(free_cnt[3:0]), 64'd5);

        // Reset while H holds a stalled group
        send(2'b11, 4'b0100, 8'h00);
        tick();
        idle();
        stall = 1'b1;
        rst = 1'b1;
        tick();
        idle();
        #1;
        check("rst_rdy", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_we", 64'(dp_we), 64'd0);
        check("rst_free", 64'(free_cnt), 64'h8888);
        tick();
        check("rst_h_we", 64'(dp_we), 64'd0);
        check("rst_h_busy", 64'(busy), 64'd0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst = ($urandom_range(0, 199) == 0);
            in_valid = 2'($urandom_range(0, 3));
            in_rs_id = 4'($urandom);
            in_spec_tag = 8'($urandom);
            stall = ($urandom_range(0, 4) == 0);
            k = $urandom_range(0, 19);
            br_kill = (k == 0);
            br_clear = (k == 1);
            br_mask = 4'b0001 << $urandom_range(0, 3);
            for (int r = 0; r < 4; r++) begin
                if ($urandom_range(0, 2) == 0) begin
                    e = $urandom_range(0, 7);
                    if (mb[r][e]) begin
                        rel_valid[r] = 1'b1;
                        rel_idx[r*3 +: 3] = 3'(e);
                    end
                end
            end
            tick();
        end
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
